mc_apb_master: RTL and testbench
================================

# mc_apb_master

APB initiator for the memory-controller configuration bus. It converts a simple valid/ready command interface into APB3 SETUP/ACCESS transfers toward the MC register block, and returns read data or a timeout error on a one-cycle response strobe. An optional boot sequencer programs the MC timing registers and sets `mc_en` after reset, with no software involvement.

## Interface

Parameters:
- `APB_ADDR_WIDTH`, default 16: APB and command address width.
- `APB_DATA_WIDTH`, default 32: APB and command data width.
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS cycles allowed without `apb_pready`. 0 disables the timeout. Legal range 0..255; the counter is 8 bits.

Ports:
- `apb_pclk`, in, 1: clock.
- `apb_prstn`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: command accepted when high together with `cmd_valid`.
- `cmd_write`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, `APB_ADDR_WIDTH`: target address.
- `cmd_wdata`, in, `APB_DATA_WIDTH`: write data.
- `rsp_valid`, out, 1: one-cycle completion strobe.
- `rsp_rdata`, out, `APB_DATA_WIDTH`: read data. 0 for writes and on timeout.
- `rsp_err`, out, 1: timeout flag, qualified by `rsp_valid`.
- `boot_done`, out, 1: boot sequence finished; command path enabled.
- `apb_psel`, `apb_penable`, `apb_pwrite`, out, 1 each: APB control.
- `apb_paddr`, out, `APB_ADDR_WIDTH`: APB address.
- `apb_pwdata`, out, `APB_DATA_WIDTH`: APB write data.
- `apb_prdata`, in, `APB_DATA_WIDTH`: APB read data.
- `apb_pready`, in, 1: APB ready.

## Operation

- All outputs are registered.
- **Reset values:** every APB output is 0; `cmd_ready` = 0; `rsp_valid` = 0; `rsp_rdata` = 0; `rsp_err` = 0; `boot_done` = 0 with the macro, 1 without.
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE: `apb_psel`, `apb_penable` and `apb_pwrite` are all 0. The responder writes on `penable && pwrite` without checking `psel`, so `pwrite` must never be left high outside a transfer.
  - IDLE -> SETUP: on handshake (`cmd_valid && cmd_ready`), or when a boot entry is pending. Address, data and direction are latched at this point and held stable through ACCESS.
  - SETUP: `psel` = 1, `penable` = 0. Always lasts exactly 1 cycle, then moves to ACCESS.
  - ACCESS: `psel` = 1, `penable` = 1. Exits to IDLE when `apb_pready` = 1, or on timeout.
    - On pready: reads capture `apb_prdata` into `rsp_rdata`; writes load 0.
    - On timeout: `psel` and `penable` are dropped, `rsp_err` = 1, `rsp_rdata` = 0.
- **cmd_ready:** 1 only when state = IDLE and `boot_done` = 1. There is no queuing; at most one outstanding command.
- **Timeout counter:** clears on SETUP entry and increments each ACCESS cycle without pready. Timeout fires when the count reaches `TIMEOUT_CYCLES`. If pready and timeout coincide in the same cycle, pready wins and `rsp_err` = 0.
- **Reset mid-transfer:** all APB outputs drop asynchronously. No response is issued, and the boot sequence restarts from entry 0.

## Timing

- Handshake in cycle 0 -> SETUP in cycle 1 -> ACCESS in cycle 2.
- With pready = 1 in cycle 2: `rsp_valid` = 1 and `cmd_ready` = 1 in cycle 3.
- Minimum command-to-command spacing is 3 cycles.
- Each wait state adds 1 cycle.
- `rsp_valid` is high for exactly one cycle; `rsp_rdata` and `rsp_err` hold their values until the next response.

## Configuration

Macro: `MC_APB_BOOT_INIT_EN`.

- **Defined:** after reset release, the block issues 5 back-to-back APB writes, each with the same IDLE -> SETUP -> ACCESS timing as a command, in this order:
  1. 0x4 <- 0x07061016
  2. 0x8 <- 0x00000406
  3. 0xC <- 0x0FFFFFFF
  4. 0x10 <- 0x016E3600
  5. 0x0 <- 0x00000001

  `mc_en` is written last. Boot writes produce no `rsp_valid`. A timed-out boot entry is skipped and the sequence continues. `boot_done` goes to 1 in the cycle after the final entry's ACCESS completes, and `cmd_ready` rises with it.
- **Not defined:** there is no boot logic, `boot_done` is tied to 1, and `cmd_ready` = 1 from the first cycle after reset.

## Test plan

- **Write path:** write 0x8 <- 0x00000A05 with pready tied to 1 -> SETUP in cycle 1 with `pwrite` = 1 and `paddr` = 0x8; ACCESS in cycle 2; `rsp_valid` in cycle 3 with `rsp_err` = 0 and `rsp_rdata` = 0; a following read of 0x8 returns 0x00000A05.
- **Read with wait states:** read 0x10 with pready held 0 for 3 ACCESS cycles and `prdata` = 0x016E3600 -> `rsp_valid` 6 cycles after the handshake, `rsp_rdata` = 0x016E3600, and `psel`/`paddr` stable throughout.
- **Timeout:** `TIMEOUT_CYCLES` = 4 and pready stuck at 0 -> `psel` drops after 4 ACCESS cycles, `rsp_err` = 1, `rsp_rdata` = 0, `cmd_ready` returns to 1.
- **Boot sequence (macro defined):** after reset -> exactly 5 writes in the listed order, `boot_done` rises after the 0x0 write, and `cmd_ready` stays 0 until then.
- **Reset mid-ACCESS:** assert `apb_prstn` low during ACCESS -> `psel`, `penable` and `pwrite` go to 0 asynchronously, no `rsp_valid`; the boot sequence restarts from 0x4.

Source files
------------

// File: rtl/mc_apb_master.sv
// mc_apb_master: valid/ready command port to APB3 initiator with an ACCESS-phase timeout.
// Define MC_APB_BOOT_INIT_EN to program the MC timing registers and mc_en after reset.
module mc_apb_master #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      apb_pclk,
  input  logic                      apb_prstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      boot_done,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
  input  logic                      apb_pready
);

  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);
  localparam bit         TMO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [7:0]                r_tmo_cnt;
  logic                      r_cmd_ready;
  logic                      r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;

  logic                      w_start;
  logic                      w_done;
  logic                      w_tmo_hit;
  logic [8:0]                w_tmo_inc;
  logic                      w_boot_pend;
  logic                      w_boot_done_nxt;
  logic [APB_ADDR_WIDTH-1:0] w_boot_addr;
  logic [APB_DATA_WIDTH-1:0] w_boot_wdata;
  logic                      w_start_write;
  logic [APB_ADDR_WIDTH-1:0] w_start_addr;
  logic [APB_DATA_WIDTH-1:0] w_start_wdata;

`ifdef MC_APB_BOOT_INIT_EN
  logic [2:0] r_boot_idx;
  logic       r_boot_done;
  logic       w_boot_last;

  function automatic logic [APB_ADDR_WIDTH-1:0] boot_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    boot_addr = APB_ADDR_WIDTH'(16'h0004);
      3'd1:    boot_addr = APB_ADDR_WIDTH'(16'h0008);
      3'd2:    boot_addr = APB_ADDR_WIDTH'(16'h000C);
      3'd3:    boot_addr = APB_ADDR_WIDTH'(16'h0010);
      default: boot_addr = APB_ADDR_WIDTH'(16'h0000);
    endcase
  endfunction

  // mc_en (0x0) is deliberately last so the controller only runs once timings are in place
  function automatic logic [APB_DATA_WIDTH-1:0] boot_wdata(input logic [2:0] idx);
    case (idx)
      3'd0:    boot_wdata = APB_DATA_WIDTH'(32'h0706_1016);
      3'd1:    boot_wdata = APB_DATA_WIDTH'(32'h0000_0406);
      3'd2:    boot_wdata = APB_DATA_WIDTH'(32'h0FFF_FFFF);
      3'd3:    boot_wdata = APB_DATA_WIDTH'(32'h016E_3600);
      default: boot_wdata = APB_DATA_WIDTH'(32'h0000_0001);
    endcase
  endfunction

  assign w_boot_pend     = !r_boot_done;
  assign w_boot_last     = (r_boot_idx == 3'd4);
  assign w_boot_done_nxt = r_boot_done | (w_done & w_boot_last);
  assign w_boot_addr     = boot_addr(r_boot_idx);
  assign w_boot_wdata    = boot_wdata(r_boot_idx);
  assign boot_done       = r_boot_done;

  // a timed-out entry still advances the index, so a dead register cannot stall boot
  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_boot_idx  <= 3'd0;
      r_boot_done <= 1'b0;
    end else if (w_done && !r_boot_done) begin
      if (w_boot_last) r_boot_done <= 1'b1;
      else             r_boot_idx  <= r_boot_idx + 3'd1;
    end
  end
`else
  assign w_boot_pend     = 1'b0;
  assign w_boot_done_nxt = 1'b1;
  assign w_boot_addr     = '0;
  assign w_boot_wdata    = '0;
  assign boot_done       = 1'b1;
`endif

  assign w_start_write = w_boot_pend ? 1'b1         : cmd_write;
  assign w_start_addr  = w_boot_pend ? w_boot_addr  : cmd_addr;
  assign w_start_wdata = w_boot_pend ? w_boot_wdata : cmd_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo_hit   = 1'b0;
    w_tmo_inc   = {1'b0, r_tmo_cnt} + 9'd1;
    case (r_state)
      S_IDLE: begin
        if (w_boot_pend || (cmd_valid && r_cmd_ready)) begin
          w_start     = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        // pready is tested first so it wins over a coincident timeout
        if (apb_pready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (TMO_EN && (w_tmo_inc == TMO_LIMIT)) begin
          w_done      = 1'b1;
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_tmo_cnt   <= 8'd0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= (w_state_nxt != S_IDLE);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_cmd_ready <= (w_state_nxt == S_IDLE) && w_boot_done_nxt;
      if (w_start) begin
        r_pwrite  <= w_start_write;
        r_paddr   <= w_start_addr;
        r_pwdata  <= w_start_wdata;
        r_tmo_cnt <= 8'd0;
      end else begin
        // the responder ignores psel, so pwrite must fall with the transfer
        if (w_done) r_pwrite <= 1'b0;
        if ((r_state == S_ACCESS) && !apb_pready) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done && !w_boot_pend;
      if (w_done && !w_boot_pend) begin
        r_rsp_rdata <= (w_tmo_hit || r_pwrite) ? '0 : apb_prdata;
        r_rsp_err   <= w_tmo_hit;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign apb_psel    = r_psel;
  assign apb_penable = r_penable;
  assign apb_pwrite  = r_pwrite;
  assign apb_paddr   = r_paddr;
  assign apb_pwdata  = r_pwdata;

endmodule

// File: tb/tb_mc_apb_master.sv
// Testbench for mc_apb_master: transaction-timeline model plus directed literal checks.
`timescale 1ns/1ps
module tb_mc_apb_master;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;
`ifdef MC_APB_BOOT_INIT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          prstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_err, boot_done;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;

  int            tb_waits = 0;
  int            acc_cnt;
  int            wr_count;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] slave_mem [64];
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  mc_apb_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .apb_pclk   (clk),
    .apb_prstn  (prstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .boot_done  (boot_done),
    .apb_psel   (psel),
    .apb_penable(penable),
    .apb_pwrite (pwrite),
    .apb_paddr  (paddr),
    .apb_pwdata (pwdata),
    .apb_prdata (prdata),
    .apb_pready (pready)
  );

  // APB responder: ready after tb_waits stalled ACCESS cycles
  assign pready = (acc_cnt >= tb_waits);
  assign prdata = slave_mem[paddr[7:2]];

  always_ff @(posedge clk or negedge prstn) begin
    if (!prstn)                          acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                                 acc_cnt <= 0;
  end

  always_ff @(posedge clk or negedge prstn) begin
    if (!prstn) begin
      wr_count     <= 0;
      last_wr_addr <= '0;
    end else if (penable && pwrite && pready) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= paddr;
    end
  end

  always_ff @(posedge clk)
    if (penable && pwrite && pready) slave_mem[paddr[7:2]] <= pwdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  logic [AW-1:0] boot_a [5] = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0000};
  logic [DW-1:0] boot_d [5] = '{32'h07061016, 32'h00000406, 32'h0FFFFFFF, 32'h016E3600, 32'h00000001};
  logic [DW-1:0] model_mem [64];
  int            m_cyc, m_start, m_n, m_bidx, m_ph;
  bit            m_act, m_boot, m_wr, m_terr, m_bd, m_rsp_due, m_err;
  bit            e_psel, e_pen, e_pwr, e_rdy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic m_reset();
    m_cyc = 0; m_start = 0; m_n = 0; m_bidx = 0;
    m_act = 1'b0; m_bd = !BOOT_EN; m_rsp_due = 1'b0; m_err = 1'b0; m_rdata = '0;
  endtask

  // a transfer occupies SETUP then n ACCESS cycles; n is set by the responder's wait count
  task automatic m_begin(input bit b, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_act = 1'b1; m_start = m_cyc; m_boot = b; m_wr = w; m_addr = a; m_wdata = d;
    m_terr = (TMO != 0) && (tb_waits >= TMO);
    m_n = m_terr ? TMO : tb_waits + 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!prstn) begin
        m_reset();
      end else begin
        m_ph   = m_cyc - m_start;
        e_psel = m_act;
        e_pen  = m_act && (m_ph >= 2);
        e_pwr  = m_act && m_wr;
        e_rdy  = !m_act && m_bd && (m_cyc >= 1);
        chk("psel", 32'(psel), 32'(e_psel));
        chk("penable", 32'(penable), 32'(e_pen));
        chk("pwrite", 32'(pwrite), 32'(e_pwr));
        if (m_act) chk("paddr", 32'(paddr), 32'(m_addr));
        if (m_act && m_wr) chk("pwdata", pwdata, m_wdata);
        chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
        chk("boot_done", 32'(boot_done), 32'(m_bd));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_due));
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        m_rsp_due = 1'b0;
        if (m_act) begin
          if (m_ph == m_n + 1) begin
            m_act = 1'b0;
            if (m_wr && !m_terr) model_mem[m_addr[7:2]] = m_wdata;
            if (m_boot) begin
              if (m_bidx == 4) m_bd = 1'b1;
              else             m_bidx++;
            end else begin
              m_rsp_due = 1'b1;
              m_err     = m_terr;
              m_rdata   = (m_terr || m_wr) ? '0 : model_mem[m_addr[7:2]];
            end
          end
        end else if (!m_bd) begin
          m_begin(1'b1, 1'b1, boot_a[m_bidx], boot_d[m_bidx]);
        end else if (e_rdy && cmd_valid) begin
          m_begin(1'b0, cmd_write, cmd_addr, cmd_wdata);
        end
        m_cyc++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic          s_psel, s_pen, s_pwrite;
  logic [AW-1:0] s_paddr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      $display("FAIL ready_wait: cmd_ready still %b after %0d cycles, required 1", cmd_ready, k);
    end
  endtask

  task automatic do_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, output int lat);
    wait_ready();
    tb_waits  = waits;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    s_psel = psel; s_pen = penable; s_pwrite = pwrite; s_paddr = paddr;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_boot_done", 32'(boot_done), BOOT_EN ? 32'd0 : 32'd1);
    prstn = 1'b1;

    wait_ready();
    chk("boot_wr_count", 32'(wr_count), BOOT_EN ? 32'd5 : 32'd0);
`ifdef MC_APB_BOOT_INIT_EN
    chk("boot_last_addr", 32'(last_wr_addr), 32'h0);
    chk("boot_mem_0x4", slave_mem[1], 32'h07061016);
    chk("boot_mem_0x0", slave_mem[0], 32'h00000001);
`endif

    do_cmd(1'b1, 16'h0008, 32'h00000A05, 0, lat);
    chk("wr_setup_psel", 32'(s_psel), 32'd1);
    chk("wr_setup_penable", 32'(s_pen), 32'd0);
    chk("wr_setup_pwrite", 32'(s_pwrite), 32'd1);
    chk("wr_setup_paddr", 32'(s_paddr), 32'h8);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);

    do_cmd(1'b0, 16'h0008, 32'h0, 0, lat);
    chk("rd8_setup_pwrite", 32'(s_pwrite), 32'd0);
    chk("rd8_latency", 32'(lat), 32'd3);
    chk("rd8_rdata", rsp_rdata, 32'h00000A05);

    do_cmd(1'b1, 16'h0010, 32'h016E3600, 1, lat);
    chk("wr10_latency", 32'(lat), 32'd4);

    do_cmd(1'b0, 16'h0010, 32'h0, 3, lat);
    chk("rd10_wait_latency", 32'(lat), 32'd6);
    chk("rd10_rdata", rsp_rdata, 32'h016E3600);
    chk("rd10_rsp_err", 32'(rsp_err), 32'd0);

    do_cmd(1'b0, 16'h0008, 32'h0, 1000, lat);
    chk("tmo_latency", 32'(lat), 32'd6);
    chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
    chk("tmo_psel", 32'(psel), 32'd0);
    tick();
    chk("tmo_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("tmo_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("tmo_err_held", 32'(rsp_err), 32'd1);

    do_cmd(1'b1, 16'h0020, 32'hDEADBEEF, 2, lat);
    chk("wr20_latency", 32'(lat), 32'd5);
    do_cmd(1'b0, 16'h0020, 32'h0, 0, lat);
    chk("rd20_rdata", rsp_rdata, 32'hDEADBEEF);

    // abort a stalled write with reset in its first ACCESS cycle
    wait_ready();
    tb_waits  = 3;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0024;
    cmd_wdata = 32'h12345678;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_penable", 32'(penable), 32'd1);
    chk("pre_rst_pwrite", 32'(pwrite), 32'd1);
    #1 prstn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    chk("async_rst_pwrite", 32'(pwrite), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 prstn = 1'b1;
    tick();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef MC_APB_BOOT_INIT_EN
    chk("reboot_psel", 32'(psel), 32'd1);
    chk("reboot_first_addr", 32'(paddr), 32'h4);
`else
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
`endif
    wait_ready();
    chk("reboot_wr_count", 32'(wr_count), BOOT_EN ? 32'd5 : 32'd0);

    do_cmd(1'b0, 16'h0020, 32'h0, 1, lat);
    chk("post_rst_rd_latency", 32'(lat), 32'd4);
    chk("post_rst_rd_rdata", rsp_rdata, 32'hDEADBEEF);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
